// File: rtl/data_axi_lite_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : data_axi_lite_bridge_if
//  Purpose  : 32-bit AXI-Lite bus bundle between the data-side bridge
//             (master) and the memory system (slave).
//  Signals  : AW channel  awaddr/awprot/awvalid/awready
//             W  channel  wdata/wstrb/wvalid/wready
//             B  channel  bresp/bvalid/bready
//             AR channel  araddr/arprot/arvalid/arready
//             R  channel  rdata/rresp/rvalid/rready
//  Revision : 1.0  initial release
// ============================================================================
interface data_axi_lite_bridge_if;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid,    input wready,
      input  bresp, bvalid,           output bready,
      output araddr, arprot, arvalid, input arready,
      input  rdata, rresp, rvalid,    output rready
   );

   modport slave (
      input  awaddr, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid,    output wready,
      output bresp, bvalid,           input bready,
      input  araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid,    input rready
   );
endinterface
`default_nettype wire

// File: rtl/data_axi_lite_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : data_axi_lite_bridge
//  Purpose  : Turns the MEM stage's single-cycle SRAM-style request into one
//             AXI-Lite read or write, stalls the pipeline until it finishes,
//             and returns load data. MEM uses big-endian lane order
//             (sel[3] = data[31:24] = byte address 0); AXI is little-endian.
//  Ports    : clk, rst_n           clock, asynchronous active-low reset
//             i_mem_ce/we/sel/addr/write_data   request from MEM
//             i_flush              suppresses a new request in IDLE
//             i_pipe_stall         pipeline held by another source
//             o_mem_read_data      load data, MEM lane order
//             o_stall_req          hold pipeline while a transaction is open
//             o_bus_err            one-cycle pulse on non-OKAY response
//             axi                  AXI-Lite master modport
//  Revision : 1.0  initial release
// ============================================================================
module data_axi_lite_bridge #(
   parameter bit         BYTE_SWAP = 1'b1,
   parameter logic [2:0] AXI_PROT  = 3'b000
) (
   input  wire                     clk,
   input  wire                     rst_n,
   input  wire                     i_mem_ce,
   input  wire                     i_mem_we,
   input  wire  [3:0]              i_mem_sel,
   input  wire  [31:0]             i_mem_addr,
   input  wire  [31:0]             i_mem_write_data,
   input  wire                     i_flush,
   input  wire                     i_pipe_stall,
   output logic [31:0]             o_mem_read_data,
   output logic                    o_stall_req,
   output logic                    o_bus_err,
   data_axi_lite_bridge_if.master  axi
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] RD_A  = 3'd1;
   localparam logic [2:0] RD_D  = 3'd2;
   localparam logic [2:0] WR_AW = 3'd3;
   localparam logic [2:0] WR_B  = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   logic [2:0]  r_state;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic        r_aw_done;
   logic        r_w_done;
   logic [31:0] r_rdata;
   logic        r_bus_err;

   logic        w_req;
   logic        w_aw_fire;
   logic        w_w_fire;
   logic [31:0] w_wdata_axi;
   logic [3:0]  w_wstrb_axi;
   logic [31:0] w_rdata_mem;
   logic        w_unused_addr_lsb;

   // Word-aligned bus: the byte offset is carried by the strobes only.
   assign w_unused_addr_lsb = ^i_mem_addr[1:0];

   assign w_req = i_mem_ce & ~i_flush;

   function automatic logic [31:0] f_swap32(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   generate
      if (BYTE_SWAP) begin : g_swap
         assign w_wdata_axi = f_swap32(i_mem_write_data);
         assign w_wstrb_axi = {i_mem_sel[0], i_mem_sel[1], i_mem_sel[2], i_mem_sel[3]};
         assign w_rdata_mem = f_swap32(axi.rdata);
      end else begin : g_pass
         assign w_wdata_axi = i_mem_write_data;
         assign w_wstrb_axi = i_mem_sel;
         assign w_rdata_mem = axi.rdata;
      end
   endgenerate

   // Valids/readies are decoded from state alone so an async reset drops
   // them in the same instant the state register clears.
   assign axi.arvalid = (r_state == RD_A);
   assign axi.rready  = (r_state == RD_D);
   assign axi.awvalid = (r_state == WR_AW) & ~r_aw_done;
   assign axi.wvalid  = (r_state == WR_AW) & ~r_w_done;
   assign axi.bready  = (r_state == WR_B);
   assign axi.awaddr  = r_addr;
   assign axi.araddr  = r_addr;
   assign axi.awprot  = AXI_PROT;
   assign axi.arprot  = AXI_PROT;
   assign axi.wdata   = r_wdata;
   assign axi.wstrb   = r_wstrb;

   assign w_aw_fire = axi.awvalid & axi.awready;
   assign w_w_fire  = axi.wvalid  & axi.wready;

   assign o_stall_req = ((r_state == IDLE) & w_req) |
                        (r_state == RD_A) | (r_state == RD_D) |
                        (r_state == WR_AW) | (r_state == WR_B);
   assign o_mem_read_data = r_rdata;
   assign o_bus_err       = r_bus_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_addr    <= 32'h0;
         r_wdata   <= 32'h0;
         r_wstrb   <= 4'h0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_rdata   <= 32'h0;
         r_bus_err <= 1'b0;
      end else begin
         r_bus_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_addr    <= {i_mem_addr[31:2], 2'b00};
                  r_wdata   <= w_wdata_axi;
                  r_wstrb   <= w_wstrb_axi;
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_state   <= i_mem_we ? WR_AW : RD_A;
               end
            end
            RD_A: begin
               if (axi.arready) r_state <= RD_D;
            end
            RD_D: begin
               if (axi.rvalid) begin
                  r_rdata   <= w_rdata_mem;
                  r_bus_err <= |axi.rresp;
                  r_state   <= DONE;
               end
            end
            WR_AW: begin
               // AW and W complete independently; leave once both have fired,
               // counting a handshake happening in this very cycle.
               if (w_aw_fire) r_aw_done <= 1'b1;
               if (w_w_fire)  r_w_done  <= 1'b1;
               if ((r_aw_done | w_aw_fire) && (r_w_done | w_w_fire))
                  r_state <= WR_B;
            end
            WR_B: begin
               if (axi.bvalid) begin
                  r_bus_err <= |axi.bresp;
                  r_state   <= DONE;
               end
            end
            DONE: begin
               // Request inputs are ignored here, so a held request is never reissued.
               if (!i_pipe_stall) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
